// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel enable, sync/blank, next-pixel lookahead.
// Counters advance on pix_en cycles; outputs track them with no lag.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       r_pix_en;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_blank_n;
  logic [9:0] r_next_x;
  logic [9:0] r_next_y;
  logic       r_frame_start;
  logic [7:0] r_frame_cnt;

  logic       w_h_last;
  logic       w_v_last;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_h2_last;
  logic       w_v2_last;
  logic [9:0] w_nx;
  logic [9:0] w_ny;
  logic       w_wrap_next;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_h_nxt  = w_h_last ? 10'd0 : r_h_cnt + 10'd1;
  assign w_v_nxt  = !w_h_last ? r_v_cnt :
                    (w_v_last ? 10'd0 : r_v_cnt + 10'd1);

  // Lookahead is derived from the counter values about to be loaded
  assign w_h2_last = (w_h_nxt == H_LAST);
  assign w_v2_last = (w_v_nxt == V_LAST);
  assign w_nx = w_h2_last ? 10'd0 : w_h_nxt + 10'd1;
  assign w_ny = !w_h2_last ? w_v_nxt :
                (w_v2_last ? 10'd0 : w_v_nxt + 10'd1);

  // Pulse lands in the pix_en=1 cycle holding the last pixel of the frame
  assign w_wrap_next = ~r_pix_en & w_h_last & w_v_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_en      <= 1'b0;
      r_h_cnt       <= 10'd0;
      r_v_cnt       <= 10'd0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b1;
      r_next_x      <= 10'd1;
      r_next_y      <= 10'd0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else begin
      r_pix_en      <= ~r_pix_en;
      r_frame_start <= w_wrap_next;
      if (r_frame_start) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (r_pix_en) begin
        r_h_cnt   <= w_h_nxt;
        r_v_cnt   <= w_v_nxt;
        r_hsync   <= !((w_h_nxt >= HS_BEG) && (w_h_nxt <= HS_END));
        r_vsync   <= !((w_v_nxt >= VS_BEG) && (w_v_nxt <= VS_END));
        r_blank_n <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
        r_next_x  <= w_nx;
        r_next_y  <= w_ny;
      end
    end
  end

  assign pix_en      = r_pix_en;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank_n     = r_blank_n;
  assign next_x      = r_next_x;
  assign next_y      = r_next_y;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-raster and default-raster instances.
// Closed-form expectations queued per cycle, popped by a negedge monitor.
module tb_vga_timing_gen;

  typedef struct {
    int k;
    int pe;
    int hs;
    int vs;
    int bl;
    int nx;
    int ny;
    int fs;
    int fc;
  } vec_t;

  localparam int X = -1;

  logic clk;
  logic rst_s;
  logic rst_d;

  logic       pe_s, hs_s, vs_s, bl_s, fs_s;
  logic [9:0] nx_s, ny_s;
  logic [7:0] fc_s;
  logic       pe_d, hs_d, vs_d, bl_d, fs_d;
  logic [9:0] nx_d, ny_d;
  logic [7:0] fc_d;

  int vectors = 0;
  int miscompares = 0;
  int ks = -1;
  int kd = -1;

  vec_t qs[$];
  vec_t qd[$];
  vec_t hand_s[$];
  vec_t hand_d[$];

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clk(clk), .rst(rst_s), .pix_en(pe_s),
    .hsync(hs_s), .vsync(vs_s), .blank_n(bl_s),
    .next_x(nx_s), .next_y(ny_s),
    .frame_start(fs_s), .frame_cnt(fc_s)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst_d), .pix_en(pe_d),
    .hsync(hs_d), .vsync(vs_d), .blank_n(bl_d),
    .next_x(nx_d), .next_y(ny_d),
    .frame_start(fs_d), .frame_cnt(fc_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t model(input int k,
    input int ha, input int hf, input int hsw, input int hb,
    input int va, input int vf, input int vsw, input int vb);
    vec_t e;
    int ht, vt, n, h, v;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    n = k / 2;
    h = n % ht;
    v = (n / ht) % vt;
    e.k  = k;
    e.pe = k % 2;
    e.hs = (h >= ha + hf && h < ha + hf + hsw) ? 0 : 1;
    e.vs = (v >= va + vf && v < va + vf + vsw) ? 0 : 1;
    e.bl = (h < ha && v < va) ? 1 : 0;
    e.nx = (h == ht - 1) ? 0 : h + 1;
    e.ny = (h != ht - 1) ? v : ((v == vt - 1) ? 0 : v + 1);
    e.fs = (e.pe == 1 && h == ht - 1 && v == vt - 1) ? 1 : 0;
    e.fc = (n / (ht * vt)) % 256;
    return e;
  endfunction

  function automatic vec_t act(input logic pe, input logic hs,
    input logic vs, input logic bl, input logic [9:0] nx,
    input logic [9:0] ny, input logic fs, input logic [7:0] fc);
    vec_t a;
    a.k = 0;
    a.pe = int'(pe);
    a.hs = int'(hs);
    a.vs = int'(vs);
    a.bl = int'(bl);
    a.nx = int'(nx);
    a.ny = int'(ny);
    a.fs = int'(fs);
    a.fc = int'(fc);
    return a;
  endfunction

  function automatic bit fld_ok(input int a, input int e);
    return (e < 0) || (a == e);
  endfunction

  function automatic bit match(input vec_t a, input vec_t e);
    return fld_ok(a.pe, e.pe) && fld_ok(a.hs, e.hs) &&
           fld_ok(a.vs, e.vs) && fld_ok(a.bl, e.bl) &&
           fld_ok(a.nx, e.nx) && fld_ok(a.ny, e.ny) &&
           fld_ok(a.fs, e.fs) && fld_ok(a.fc, e.fc);
  endfunction

  function automatic string fmt(input vec_t v);
    return $sformatf("pe=%0d hs=%0d vs=%0d bl=%0d nx=%0d ny=%0d fs=%0d fc=%0d",
      v.pe, v.hs, v.vs, v.bl, v.nx, v.ny, v.fs, v.fc);
  endfunction

  task automatic add(input bit dflt, input int k, input int pe,
    input int hs, input int vs, input int bl, input int nx,
    input int ny, input int fs, input int fc);
    vec_t v;
    v.k = k; v.pe = pe; v.hs = hs; v.vs = vs; v.bl = bl;
    v.nx = nx; v.ny = ny; v.fs = fs; v.fc = fc;
    if (dflt) hand_d.push_back(v);
    else hand_s.push_back(v);
  endtask

  task automatic check(input string nm, input int k,
    input vec_t a, input vec_t e);
    vectors++;
    if (!match(a, e)) begin
      miscompares++;
      $display("FAIL %s k=%0d got {%s} want {%s}", nm, k, fmt(a), fmt(e));
    end
  endtask

  // Reference: k counts clocks since the last reset edge
  always @(posedge clk) begin
    if (rst_s) ks = 0;
    else if (ks >= 0) ks = ks + 1;
    if (rst_d) kd = 0;
    else if (kd >= 0) kd = kd + 1;
    if (ks >= 0) qs.push_back(model(ks, 4, 2, 2, 2, 3, 1, 1, 1));
    if (kd >= 0) qd.push_back(model(kd, 640, 16, 96, 48, 480, 10, 2, 33));
  end

  always @(negedge clk) begin
    vec_t e, a;
    while (qs.size() > 0) begin
      e = qs.pop_front();
      a = act(pe_s, hs_s, vs_s, bl_s, nx_s, ny_s, fs_s, fc_s);
      check("small_seq", e.k, a, e);
      foreach (hand_s[i])
        if (hand_s[i].k == e.k) check("small_dir", e.k, a, hand_s[i]);
    end
    while (qd.size() > 0) begin
      e = qd.pop_front();
      a = act(pe_d, hs_d, vs_d, bl_d, nx_d, ny_d, fs_d, fc_d);
      check("dflt_seq", e.k, a, e);
      foreach (hand_d[i])
        if (hand_d[i].k == e.k) check("dflt_dir", e.k, a, hand_d[i]);
    end
  end

  initial begin
    bit found;
    // small raster: 10 px x 6 lines, hsync low px 6..7, vsync low line 4
    add(0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
    add(0, 1, 1, X, X, X, 1, X, X, X);
    add(0, 2, 0, X, X, X, 2, X, X, X);
    add(0, 7, X, X, X, 1, 4, X, X, X);
    add(0, 8, X, X, X, 0, 5, X, X, X);
    add(0, 11, X, 1, X, X, X, X, X, X);
    add(0, 12, X, 0, X, X, X, X, X, X);
    add(0, 15, X, 0, X, X, X, X, X, X);
    add(0, 16, X, 1, X, X, X, X, X, X);
    add(0, 19, 1, X, X, X, 0, 1, 0, X);
    add(0, 79, X, X, 1, X, X, X, X, X);
    add(0, 80, X, X, 0, 0, X, X, X, X);
    add(0, 94, X, 0, 0, X, 8, 4, X, X);
    add(0, 99, X, X, 0, X, X, X, X, X);
    add(0, 100, X, X, 1, X, X, X, X, X);
    add(0, 118, 0, X, X, X, 0, 0, 0, 0);
    add(0, 119, 1, X, X, X, X, X, 1, 0);
    add(0, 120, 0, 1, 1, 1, 1, 0, 0, 1);
    add(0, 239, X, X, X, X, X, X, 1, 1);
    add(0, 240, X, X, X, X, X, X, 0, 2);
    add(0, 30719, X, X, X, X, X, X, 1, 255);
    add(0, 30720, X, X, X, X, X, X, 0, 0);
    // default 640x480 raster
    add(1, 0, 0, 1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 1, X, X, X, 1, X, X, X);
    add(1, 2, 0, X, X, X, 2, X, X, X);
    add(1, 3, 1, X, X, X, 2, X, X, X);
    add(1, 1279, X, X, X, 1, 640, X, X, X);
    add(1, 1280, X, X, X, 0, 641, X, X, X);
    add(1, 1311, X, 1, X, X, X, X, X, X);
    add(1, 1312, X, 0, X, X, 657, X, X, X);
    add(1, 1503, X, 0, X, X, X, X, X, X);
    add(1, 1504, X, 1, X, X, X, X, X, X);
    add(1, 1599, 1, X, X, X, 0, 1, 0, X);
    add(1, 17599, 1, X, X, X, 0, 11, 0, X);
    add(1, 17600, 0, 1, 1, 1, 1, 11, 0, 0);

    rst_s = 1'b1;
    rst_d = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_s = 1'b0;
    rst_d = 1'b0;
    repeat (30730) @(posedge clk);

    // Mid-frame reset while small raster sits at (7,4): both syncs low
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (((ks / 2) % 60) == 47) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL midreset_wait got=timeout want=pixel(7,4)");
    end
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1 bit: 50 MHz system clock; all logic on its rising edge.
REQ-010 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-011 SHALL have port pix_en, output, 1 bit: pixel-clock enable at clk/2.
REQ-012 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-013 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-014 SHALL have port blank_n, output, 1 bit: high while the current pixel is visible.
REQ-015 SHALL have port next_x, output, 10 bits: column of the next pixel slot, fed to downstream color generators.
REQ-016 SHALL have port next_y, output, 10 bits: line of the next pixel slot.
REQ-017 SHALL have port frame_start, output, 1 bit: one-clk pulse at frame wrap.
REQ-018 SHALL have port frame_cnt, output, 8 bits: frames completed since reset, for animation timing.

Function
REQ-019 Totals SHALL be H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-020 pix_en SHALL toggle on every clk; it is 0 in the first cycle after reset release and 1 in the second.
REQ-021 Internal h_cnt (10b) SHALL increment only in cycles where pix_en=1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-022 Internal v_cnt (10b) SHALL increment only when pix_en=1 and h_cnt=H_TOTAL-1; at V_TOTAL-1 it SHALL wrap to 0 on that same pixel.
REQ-023 hsync SHALL be 0 iff h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
REQ-024 vsync SHALL be 0 iff v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491].
REQ-025 blank_n SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-026 hsync, vsync, and blank_n SHALL be registered and SHALL reflect the counter values held in the same cycle, with no extra pixel of latency.
REQ-027 next_x SHALL equal h_cnt+1, or 0 when h_cnt=H_TOTAL-1; it is not clamped during blanking, so values 640..799 are legal.
REQ-028 next_y SHALL equal v_cnt, except when h_cnt=H_TOTAL-1, where it SHALL equal v_cnt+1, or 0 if v_cnt=V_TOTAL-1.
REQ-029 This one-pixel lookahead SHALL let a downstream stage that registers color from next_x/next_y present that color aligned with blank_n.
REQ-030 frame_start SHALL be 1 for exactly one clk, in the cycle where pix_en=1, h_cnt=799 and v_cnt=524 (the cycle the counters wrap), and 0 otherwise.
REQ-031 frame_cnt SHALL increment by 1 in the cycle frame_start=1, wrapping 255->0.
REQ-032 All outputs SHALL hold their values in cycles where pix_en=0, except pix_en itself.

Reset
REQ-033 While rst=1 at a clk edge, the block SHALL set pix_en=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1, blank_n=1, next_x=1, next_y=0, frame_start=0 and frame_cnt=0.
REQ-034 Asserting rst mid-line or mid-frame SHALL abort the frame immediately, with no partial sync pulse held; timing restarts from pixel (0,0) after release.

Verification
REQ-035 Reset release: after rst 1->0, pix_en SHALL read 0,1,0,1; h_cnt SHALL advance 0->1 on the 2nd post-reset cycle; next_x SHALL advance 1->2.
REQ-036 Line timing: over one line, hsync low SHALL last 96 pixels (192 clk), starting 656 pixels after line start; blank_n high for pixels 0..639 of line 0.
REQ-037 Line wrap: at h_cnt=799 with v_cnt=10, next_x=0 and next_y=11 SHALL hold; the next pixel has h_cnt=0 and v_cnt=11.
REQ-038 Frame wrap: at h_cnt=799 and v_cnt=524, frame_start SHALL pulse for 1 clk, frame_cnt SHALL go 0->1, the counters SHALL go to (0,0), and vsync SHALL be low only on lines 490-491.
REQ-039 Full frame: the period between frame_start pulses SHALL be 800*525*2 = 840000 clk; after 256 frames frame_cnt SHALL read 0.
REQ-040 Mid-frame reset: rst asserted at h_cnt=700, v_cnt=491 (hsync=0, vsync=0) SHALL drive hsync=1 and vsync=1 on the next edge, and all outputs SHALL take their REQ-033 values.
